// File: rtl/pfifo_pop_reader.sv
// Read-side controller for the 6-bit-LLR packing FIFO: pops job chunks and re-issues them on a valid/ready stream.
// Optional build macro PFIFO_POP_LLR_CLIP_EN: clips captured LLRs of -32 to -31.
module pfifo_pop_reader #(
  parameter int MAX_CHUNK = 16,
  parameter int LEN_W     = 16
) (
  input  logic             i_core_clk,
  input  logic             i_rx_rstn,
  input  logic             i_job_start,
  input  logic [LEN_W-1:0] i_job_len,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_job_done,
  output logic             PopPermit,
  output logic [3:0]       PopAmout,
  input  logic [95:0]      PopData,
  input  logic             PopEnable,
  output logic [95:0]      o_data,
  output logic [3:0]       o_amount,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_last
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t           r_state;
  logic [LEN_W-1:0] r_remaining;
  logic             r_busy;
  logic             r_job_done;
  logic [95:0]      r_data;
  logic [3:0]       r_amount;
  logic             r_valid;
  logic             r_last;

  logic [4:0]       w_chunk;
  logic [3:0]       w_amt;
  logic             w_permit;
  logic             w_pop;
  logic             w_hs;
  logic             w_last_chunk;
  logic [95:0]      w_lanes;

  assign w_chunk      = (r_remaining >= LEN_W'(MAX_CHUNK)) ? 5'(MAX_CHUNK) : r_remaining[4:0];
  assign w_amt        = 4'(w_chunk - 5'd1);
  assign w_permit     = (r_state == ST_RUN) && (!r_valid || i_ready);
  // Pops are only honoured while permitted; stray strobes are ignored.
  assign w_pop        = PopEnable && w_permit;
  assign w_hs         = r_valid && i_ready;
  assign w_last_chunk = (r_remaining == LEN_W'(w_chunk));

  assign PopPermit  = w_permit;
  assign PopAmout   = (r_state == ST_RUN) ? w_amt : 4'd0;
  assign o_busy     = r_busy;
  assign o_job_done = r_job_done;
  assign o_data     = r_data;
  assign o_amount   = r_amount;
  assign o_valid    = r_valid;
  assign o_last     = r_last;

  // Lanes beyond the popped amount are forced to zero.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_lane
      localparam logic [3:0] LANE = 4'(gi);
      logic [5:0] w_llr;
`ifdef PFIFO_POP_LLR_CLIP_EN
      assign w_llr = (PopData[gi*6 +: 6] == 6'h20) ? 6'h21 : PopData[gi*6 +: 6];
`else
      assign w_llr = PopData[gi*6 +: 6];
`endif
      assign w_lanes[gi*6 +: 6] = (LANE <= PopAmout) ? w_llr : 6'd0;
    end
  endgenerate

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_job_done  <= 1'b0;
      r_data      <= '0;
      r_amount    <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
    end else begin
      r_job_done <= 1'b0;
      if (i_abort) begin
        r_state     <= ST_IDLE;
        r_remaining <= '0;
        r_busy      <= 1'b0;
        r_valid     <= 1'b0;
        r_last      <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_job_start && (i_job_len != '0)) begin
              r_remaining <= i_job_len;
              r_busy      <= 1'b1;
              r_state     <= ST_RUN;
            end
          end
          ST_RUN, ST_DRAIN: begin
            if (w_pop) begin
              r_data      <= w_lanes;
              r_amount    <= w_amt;
              r_valid     <= 1'b1;
              r_remaining <= r_remaining - LEN_W'(w_chunk);
              r_last      <= w_last_chunk;
              if (w_last_chunk) r_state <= ST_DRAIN;
            end else if (w_hs) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              if ((r_state == ST_DRAIN) && r_last) begin
                r_state    <= ST_IDLE;
                r_busy     <= 1'b0;
                r_job_done <= 1'b1;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pfifo_pop_reader.sv
// Directed bench for pfifo_pop_reader with a behavioural FIFO model and handshake/pop/done logging.
module tb_pfifo_pop_reader;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        job_start = 1'b0;
  logic [15:0] job_len = '0;
  logic        abort = 1'b0;
  logic        ready = 1'b0;
  logic        o_busy, o_job_done, pop_permit, pop_en, o_valid, o_last;
  logic [3:0]  pop_amt, o_amount;
  logic [95:0] pop_data, o_data;

  always #5 clk = ~clk;

  pfifo_pop_reader #(.MAX_CHUNK(16), .LEN_W(16)) dut (
    .i_core_clk(clk), .i_rx_rstn(rstn), .i_job_start(job_start), .i_job_len(job_len),
    .i_abort(abort), .o_busy(o_busy), .o_job_done(o_job_done), .PopPermit(pop_permit),
    .PopAmout(pop_amt), .PopData(pop_data), .PopEnable(pop_en), .o_data(o_data),
    .o_amount(o_amount), .o_valid(o_valid), .i_ready(ready), .o_last(o_last)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  // FIFO model: pops a full chunk only when enough LLRs are stored; junk above the chunk.
  logic [5:0] fifo_mem [0:1023];
  int rd_ptr = 0;
  int wr_ptr = 0;
  int push_n = 0;
  bit flush = 1'b0;

  always_comb begin
    pop_data = '0;
    for (int i = 0; i < 16; i++)
      pop_data[i*6 +: 6] = (i <= int'(pop_amt)) ? fifo_mem[(rd_ptr + i) % 1024] : 6'h3F;
    pop_en = pop_permit && ((wr_ptr - rd_ptr) >= int'(pop_amt) + 1);
  end

  logic [3:0]  pop_log_amt [$];
  int          pop_log_cyc [$];
  logic [95:0] hs_data [$];
  logic [3:0]  hs_amt [$];
  logic        hs_last [$];
  int          hs_cyc [$];
  int          done_cyc [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (flush) rd_ptr <= wr_ptr;
    else if (pop_en) rd_ptr <= rd_ptr + int'(pop_amt) + 1;
    wr_ptr <= wr_ptr + push_n;
    if (pop_en) begin
      pop_log_amt.push_back(pop_amt);
      pop_log_cyc.push_back(cyc);
    end
    if (o_valid && ready) begin
      hs_data.push_back(o_data);
      hs_amt.push_back(o_amount);
      hs_last.push_back(o_last);
      hs_cyc.push_back(cyc);
      $display("word: cyc=%0d amount=%0d last=%0b data=%h", cyc, o_amount, o_last, o_data);
    end
    if (o_job_done) done_cyc.push_back(cyc);
  end

  function automatic logic [95:0] exp_word(int base, int amt);
    logic [95:0] w;
    logic [5:0]  v;
    w = '0;
    for (int i = 0; i <= amt; i++) begin
      v = fifo_mem[(base + i) % 1024];
`ifdef PFIFO_POP_LLR_CLIP_EN
      if (v == 6'h20) v = 6'h21;
`endif
      w[i*6 +: 6] = v;
    end
    return w;
  endfunction

  task automatic push_llrs(int n, int seed);
    for (int i = 0; i < n; i++) fifo_mem[(wr_ptr + i) % 1024] = 6'(seed + i * 7);
    push_n = n;
    @(negedge clk);
    push_n = 0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic start_job(int len);
    job_start = 1'b1;
    job_len = 16'(len);
    @(negedge clk);
    job_start = 1'b0;
  endtask

  task automatic wait_done(int d0, string name);
    int n = 0;
    while (done_cyc.size() == d0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (done_cyc.size() != d0 + 1) $display("FAIL %s_done: got %0d done pulses, want 1", name, done_cyc.size() - d0);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({o_busy, o_job_done, pop_permit, o_valid, o_last} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", {o_busy, o_job_done, pop_permit, o_valid, o_last});
    else pass_cnt++;
    total_cnt++;
    if (o_data !== 96'd0 || o_amount !== 4'd0 || pop_amt !== 4'd0)
      $display("FAIL reset_data: got data=%h amount=%0d popamt=%0d want 0", o_data, o_amount, pop_amt);
    else pass_cnt++;
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_len40();
    int p0, h0, d0, base;
    do_flush();
    push_llrs(48, 1);
    ready = 1'b1;
    p0 = pop_log_amt.size(); h0 = hs_data.size(); d0 = done_cyc.size(); base = rd_ptr;
    start_job(40);
    wait_done(d0, "len40");
    total_cnt++;
    if (pop_log_amt.size() - p0 != 3) $display("FAIL len40_pops: got %0d want 3", pop_log_amt.size() - p0);
    else pass_cnt++;
    if (pop_log_amt.size() - p0 == 3 && hs_data.size() - h0 == 3) begin
      total_cnt++;
      if (pop_log_amt[p0] !== 4'd15 || pop_log_amt[p0+1] !== 4'd15 || pop_log_amt[p0+2] !== 4'd7)
        $display("FAIL len40_amts: got %0d,%0d,%0d want 15,15,7", pop_log_amt[p0], pop_log_amt[p0+1], pop_log_amt[p0+2]);
      else pass_cnt++;
      total_cnt++;
      if (pop_log_cyc[p0+1] != pop_log_cyc[p0] + 1 || pop_log_cyc[p0+2] != pop_log_cyc[p0] + 2)
        $display("FAIL len40_b2b: got pop cycles %0d,%0d,%0d want consecutive", pop_log_cyc[p0], pop_log_cyc[p0+1], pop_log_cyc[p0+2]);
      else pass_cnt++;
      total_cnt++;
      if (hs_data[h0] !== exp_word(base, 15) || hs_data[h0+1] !== exp_word(base + 16, 15) || hs_data[h0+2] !== exp_word(base + 32, 7))
        $display("FAIL len40_data: got %h want %h (3rd word)", hs_data[h0+2], exp_word(base + 32, 7));
      else pass_cnt++;
      total_cnt++;
      if ({hs_last[h0], hs_last[h0+1], hs_last[h0+2]} !== 3'b001)
        $display("FAIL len40_last: got %b want 001", {hs_last[h0], hs_last[h0+1], hs_last[h0+2]});
      else pass_cnt++;
      total_cnt++;
      if (done_cyc.size() > d0 && done_cyc[d0] != hs_cyc[h0+2] + 1)
        $display("FAIL len40_done_cyc: got %0d want %0d", done_cyc[d0], hs_cyc[h0+2] + 1);
      else pass_cnt++;
    end else begin
      total_cnt++;
      $display("FAIL len40_words: got %0d words want 3", hs_data.size() - h0);
    end
    repeat (2) @(negedge clk);
    total_cnt++;
    if (o_busy !== 1'b0 || done_cyc.size() != d0 + 1)
      $display("FAIL len40_idle: got busy=%b dones=%0d want busy=0 dones=1", o_busy, done_cyc.size() - d0);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    int p0, h0, d0, base, n;
    do_flush();
    push_llrs(20, 5);
    ready = 1'b1;
    p0 = pop_log_amt.size(); h0 = hs_data.size(); d0 = done_cyc.size(); base = rd_ptr;
    start_job(20);
    n = 0;
    while (!o_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    ready = 1'b0;
    total_cnt++;
    if (o_valid !== 1'b1) $display("FAIL stall_first_valid: got %b want 1", o_valid);
    else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total_cnt++;
      if (o_data !== exp_word(base, 15) || o_valid !== 1'b1)
        $display("FAIL stall_hold_%0d: got valid=%b data=%h want %h", k, o_valid, o_data, exp_word(base, 15));
      else pass_cnt++;
      total_cnt++;
      if (pop_permit !== 1'b0) $display("FAIL stall_permit_%0d: got %b want 0", k, pop_permit);
      else pass_cnt++;
    end
    total_cnt++;
    if (pop_log_amt.size() - p0 != 1) $display("FAIL stall_pops: got %0d want 1", pop_log_amt.size() - p0);
    else pass_cnt++;
    ready = 1'b1;
    wait_done(d0, "stall");
    total_cnt++;
    if (hs_data.size() - h0 != 2 || hs_amt[hs_amt.size()-1] !== 4'd3 || hs_last[hs_last.size()-1] !== 1'b1 ||
        hs_data[hs_data.size()-1] !== exp_word(base + 16, 3))
      $display("FAIL stall_word2: got words=%0d amount=%0d last=%b want 2,3,1",
               hs_data.size() - h0, hs_amt[hs_amt.size()-1], hs_last[hs_last.size()-1]);
    else pass_cnt++;
  endtask

  task automatic test_late_data();
    int p0, d0, base;
    do_flush();
    ready = 1'b1;
    p0 = pop_log_amt.size(); d0 = done_cyc.size(); base = wr_ptr;
    start_job(1);
    repeat (8) @(negedge clk);
    total_cnt++;
    if (pop_log_amt.size() != p0 || o_valid !== 1'b0 || o_busy !== 1'b1)
      $display("FAIL late_wait: got pops=%0d valid=%b busy=%b want 0,0,1", pop_log_amt.size() - p0, o_valid, o_busy);
    else pass_cnt++;
    push_llrs(1, 40);
    total_cnt++;
    if (pop_en !== 1'b1) $display("FAIL late_popen: got %b want 1", pop_en);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (o_valid !== 1'b1 || o_data !== exp_word(base, 0) || o_amount !== 4'd0 || o_last !== 1'b1)
      $display("FAIL late_word: got valid=%b data=%h amount=%0d last=%b want 1,%h,0,1",
               o_valid, o_data, o_amount, o_last, exp_word(base, 0));
    else pass_cnt++;
    wait_done(d0, "late");
  endtask

  task automatic test_abort();
    int p0, h0, d0, base, n;
    do_flush();
    push_llrs(64, 9);
    ready = 1'b1;
    p0 = pop_log_amt.size(); d0 = done_cyc.size();
    start_job(64);
    n = 0;
    while (pop_log_amt.size() < p0 + 2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    abort = 1'b1;
    ready = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    total_cnt++;
    if ({o_valid, o_busy, pop_permit, o_last} !== 4'b0)
      $display("FAIL abort_idle: got valid,busy,permit,last=%b want 0000", {o_valid, o_busy, pop_permit, o_last});
    else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (done_cyc.size() != d0 || pop_log_amt.size() != p0 + 2)
      $display("FAIL abort_nodone: got dones=%0d pops=%0d want 0,2", done_cyc.size() - d0, pop_log_amt.size() - p0);
    else pass_cnt++;
    ready = 1'b1;
    do_flush();
    push_llrs(8, 13);
    h0 = hs_data.size(); base = rd_ptr;
    start_job(8);
    wait_done(d0, "abort_restart");
    total_cnt++;
    if (hs_data.size() - h0 != 1 || hs_amt[h0] !== 4'd7 || hs_last[h0] !== 1'b1 || hs_data[h0] !== exp_word(base, 7))
      $display("FAIL abort_restart_word: got words=%0d amount=%0d last=%b want 1,7,1",
               hs_data.size() - h0, hs_amt[hs_amt.size()-1], hs_last[hs_last.size()-1]);
    else pass_cnt++;
  endtask

  task automatic test_ignored_starts();
    int h0, d0;
    do_flush();
    ready = 1'b1;
    h0 = hs_data.size(); d0 = done_cyc.size();
    start_job(5);
    total_cnt++;
    if (o_busy !== 1'b1 || pop_amt !== 4'd4) $display("FAIL ign_first: got busy=%b popamt=%0d want 1,4", o_busy, pop_amt);
    else pass_cnt++;
    start_job(3);
    @(negedge clk);
    total_cnt++;
    if (o_busy !== 1'b1 || pop_amt !== 4'd4) $display("FAIL ign_busy_start: got busy=%b popamt=%0d want 1,4", o_busy, pop_amt);
    else pass_cnt++;
    push_llrs(5, 21);
    wait_done(d0, "ign");
    total_cnt++;
    if (hs_data.size() - h0 != 1 || hs_amt[h0] !== 4'd4 || hs_last[h0] !== 1'b1)
      $display("FAIL ign_word: got words=%0d amount=%0d want 1,4", hs_data.size() - h0, hs_amt[hs_amt.size()-1]);
    else pass_cnt++;
    start_job(0);
    @(negedge clk);
    total_cnt++;
    if (o_busy !== 1'b0 || pop_permit !== 1'b0 || pop_amt !== 4'd0)
      $display("FAIL ign_len0: got busy=%b permit=%b popamt=%0d want 0,0,0", o_busy, pop_permit, pop_amt);
    else pass_cnt++;
  endtask

  task automatic test_clip();
    int d0;
    logic [95:0] want;
`ifdef PFIFO_POP_LLR_CLIP_EN
    want = 96'h7E1;
`else
    want = 96'h7E0;
`endif
    do_flush();
    ready = 1'b1;
    d0 = done_cyc.size();
    fifo_mem[wr_ptr % 1024] = 6'h20;
    fifo_mem[(wr_ptr + 1) % 1024] = 6'h1F;
    push_n = 2;
    @(negedge clk);
    push_n = 0;
    start_job(2);
    wait_done(d0, "clip");
    total_cnt++;
    if (hs_data[hs_data.size()-1] !== want || hs_amt[hs_amt.size()-1] !== 4'd1)
      $display("FAIL clip_word: got data=%h amount=%0d want %h,1", hs_data[hs_data.size()-1], hs_amt[hs_amt.size()-1], want);
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) fifo_mem[i] = '0;
    test_reset();
    test_len40();
    test_stall();
    test_late_data();
    test_abort();
    test_ignored_starts();
    test_clip();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
